// File: rtl/cm0_rst_req_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cm0_rst_req_seq_pkg
// Purpose : Shared definitions for the Cortex-M0 reset request sequencer:
//           sequencer state encoding (2-bit), RSTCAUSE bit positions and the
//           power-on value of the cause register.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package cm0_rst_req_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ASSERT  = 2'b01,
        ST_RELEASE = 2'b10,
        ST_HOLD    = 2'b11
    } state_t;

    // RSTCAUSE bit positions
    localparam int C_CAUSE_CPU  = 0;
    localparam int C_CAUSE_WDOG = 1;
    localparam int C_CAUSE_LOCK = 2;
    localparam int C_CAUSE_EXT  = 3;
    localparam int C_CAUSE_POR  = 4;

    // Power-on reset leaves only the power-on cause flagged
    localparam logic [4:0] C_CAUSE_RST = 5'(1 << C_CAUSE_POR);

endpackage : cm0_rst_req_seq_pkg
`default_nettype wire

// File: rtl/cm0_rst_debounce.sv
`default_nettype none
// ============================================================================
// Module  : cm0_rst_debounce
// Purpose : Synchronises the asynchronous external reset pin into the FCLK
//           domain and debounces it: ext_req rises once DEBOUNCE_CYCLES
//           consecutive synchronised-low samples have been seen and drops on
//           the first synchronised-high sample.
// Ports   : clk       - free-running clock
//           rst_n     - asynchronous active-low reset
//           ext_rst_n - external reset pin (asynchronous, active-low)
//           ext_req   - registered, debounced external reset request
// Revision: 1.0 - initial release
// ============================================================================
module cm0_rst_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ext_rst_n,
    output logic ext_req
);

    localparam logic [7:0] C_TARGET = 8'(DEBOUNCE_CYCLES);

    logic       r_sync1;
    logic       r_sync2;
    logic [7:0] r_cnt;
    logic       r_ext_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Synchroniser idles at the de-asserted (high) pin level
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_cnt     <= 8'd0;
            r_ext_req <= 1'b0;
        end else begin
            r_sync1 <= ext_rst_n;
            r_sync2 <= r_sync1;
            if (r_sync2) begin
                r_cnt     <= 8'd0;
                r_ext_req <= 1'b0;
            end else if (r_cnt != C_TARGET) begin
                // Counter parks at the target; the request is raised on the
                // same edge the count reaches it.
                r_cnt <= r_cnt + 8'd1;
                if (r_cnt == (C_TARGET - 8'd1)) begin
                    r_ext_req <= 1'b1;
                end
            end
        end
    end

    assign ext_req = r_ext_req;

endmodule : cm0_rst_debounce
`default_nettype wire

// File: rtl/cm0_rst_req_seq.sv
`default_nettype none
// ============================================================================
// Module  : cm0_rst_req_seq
// Purpose : Reset request sequencer in front of the Cortex-M0 reset
//           controller. Merges CPU, watchdog, lockup and debounced external
//           reset sources into one request pulse held until HRESETn is seen
//           low, waits for HRESETn release, then ignores all sources for a
//           HOLDOFF window. Keeps a sticky reset-cause register.
// Ports   : FCLK        - free-running clock
//           PORESETn    - asynchronous active-low power-on reset
//           CPURSTREQ   - core SYSRESETREQ (level)
//           WDOGRES     - watchdog reset request (level)
//           LOCKUP      - core lockup indication (level)
//           LOCKUPRESET - enables LOCKUP as a reset source
//           EXTRSTn     - external reset pin (asynchronous, active-low)
//           HRESETn     - system reset fed back from the reset controller
//           CAUSECLR    - single-cycle clear of RSTCAUSE
//           RSTREQOUT   - reset request to the reset controller
//           RSTCAUSE    - sticky cause {POR, EXT, LOCKUP, WDOG, CPU}
//           BUSY        - high whenever a sequence is in progress
// Revision: 1.0 - initial release
// ============================================================================
module cm0_rst_req_seq
    import cm0_rst_req_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned MIN_PULSE       = 4,
    parameter int unsigned HOLDOFF         = 8
) (
    input  logic       FCLK,
    input  logic       PORESETn,
    input  logic       CPURSTREQ,
    input  logic       WDOGRES,
    input  logic       LOCKUP,
    input  logic       LOCKUPRESET,
    input  logic       EXTRSTn,
    input  logic       HRESETn,
    input  logic       CAUSECLR,
    output logic       RSTREQOUT,
    output logic [4:0] RSTCAUSE,
    output logic       BUSY
);

    localparam logic [7:0] C_MIN_PULSE = 8'(MIN_PULSE);
    localparam logic [7:0] C_HOLD_LAST = 8'(HOLDOFF - 1);

    logic       w_ext_req;
    logic [4:0] w_src_cause;
    logic       w_src_any;
    logic       w_capture;

    state_t     r_state;
    logic [7:0] r_pulse_cnt;
    logic [7:0] r_hold_cnt;
    logic       r_seen_low;
    logic       r_rstreqout;
    logic       r_busy;
    logic [4:0] r_cause;

    cm0_rst_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (FCLK),
        .rst_n     (PORESETn),
        .ext_rst_n (EXTRSTn),
        .ext_req   (w_ext_req)
    );

    // Source vector laid out on the cause-register bit positions so a
    // capture can be ORed straight in; the power-on bit is never a source.
    always_comb begin
        w_src_cause               = 5'b00000;
        w_src_cause[C_CAUSE_CPU]  = CPURSTREQ;
        w_src_cause[C_CAUSE_WDOG] = WDOGRES;
        w_src_cause[C_CAUSE_LOCK] = LOCKUP & LOCKUPRESET;
        w_src_cause[C_CAUSE_EXT]  = w_ext_req;
    end

    assign w_src_any = |w_src_cause;
    // Only IDLE acts on sources; anything arriving mid-sequence is dropped
    assign w_capture = (r_state == ST_IDLE) && w_src_any;

    always_ff @(posedge FCLK or negedge PORESETn) begin
        if (!PORESETn) begin
            r_state     <= ST_IDLE;
            r_pulse_cnt <= 8'd0;
            r_hold_cnt  <= 8'd0;
            r_seen_low  <= 1'b0;
            r_rstreqout <= 1'b0;
            r_busy      <= 1'b0;
            r_cause     <= C_CAUSE_RST;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_src_any) begin
                        r_state     <= ST_ASSERT;
                        r_rstreqout <= 1'b1;
                        r_busy      <= 1'b1;
                        r_pulse_cnt <= 8'd1;
                        r_seen_low  <= 1'b0;
                    end
                end
                ST_ASSERT: begin
                    if (r_pulse_cnt != C_MIN_PULSE) begin
                        r_pulse_cnt <= r_pulse_cnt + 8'd1;
                    end
                    if (!HRESETn) begin
                        r_seen_low <= 1'b1;
                    end
                    // Registered flags: the request stays up for at least
                    // MIN_PULSE cycles and one cycle past the first low
                    // HRESETn sample. No timeout by design.
                    if ((r_pulse_cnt == C_MIN_PULSE) && r_seen_low) begin
                        r_rstreqout <= 1'b0;
                        r_state     <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (HRESETn) begin
                        r_hold_cnt <= 8'd0;
                        r_state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    r_hold_cnt <= r_hold_cnt + 8'd1;
                    if (r_hold_cnt == C_HOLD_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rstreqout <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase

            // A capture coinciding with CAUSECLR leaves exactly the new bits
            if (w_capture) begin
                r_cause <= (CAUSECLR ? 5'b00000 : r_cause) | w_src_cause;
            end else if (CAUSECLR) begin
                r_cause <= 5'b00000;
            end
        end
    end

    assign RSTREQOUT = r_rstreqout;
    assign RSTCAUSE  = r_cause;
    assign BUSY      = r_busy;

endmodule : cm0_rst_req_seq
`default_nettype wire

// File: tb/tb_cm0_rst_req_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_cm0_rst_req_seq
// Purpose : Self-checking bench for cm0_rst_req_seq. A behavioural model of
//           the request/hold-off sequence is compared against the DUT after
//           every FCLK edge; directed scenarios add literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cm0_rst_req_seq;

    localparam int DEB  = 16;
    localparam int MINP = 4;
    localparam int HOLD = 8;

    logic       FCLK;
    logic       PORESETn;
    logic       CPURSTREQ;
    logic       WDOGRES;
    logic       LOCKUP;
    logic       LOCKUPRESET;
    logic       EXTRSTn;
    logic       HRESETn;
    logic       CAUSECLR;
    logic       RSTREQOUT;
    logic [4:0] RSTCAUSE;
    logic       BUSY;

    int n_tests = 0;
    int n_fail  = 0;

    cm0_rst_req_seq #(
        .DEBOUNCE_CYCLES (DEB),
        .MIN_PULSE       (MINP),
        .HOLDOFF         (HOLD)
    ) dut (
        .FCLK        (FCLK),
        .PORESETn    (PORESETn),
        .CPURSTREQ   (CPURSTREQ),
        .WDOGRES     (WDOGRES),
        .LOCKUP      (LOCKUP),
        .LOCKUPRESET (LOCKUPRESET),
        .EXTRSTn     (EXTRSTn),
        .HRESETn     (HRESETn),
        .CAUSECLR    (CAUSECLR),
        .RSTREQOUT   (RSTREQOUT),
        .RSTCAUSE    (RSTCAUSE),
        .BUSY        (BUSY)
    );

    initial begin
        FCLK = 1'b0;
        forever #5 FCLK = ~FCLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Request is described by its age and whether a low
    // HRESETn has been seen; hold-off as a countdown; the external source as
    // the length of the low run on the pin, seen three edges late.
    // ------------------------------------------------------------------
    bit         m_req;
    bit         m_low_seen;
    bit         m_wait_rel;
    int         m_age;
    int         m_hold_left;
    int         m_run [3];
    logic [4:0] m_cause;

    always begin : p_model
        logic [3:0] src;
        bit         busy_before;
        int         newrun;
        @(posedge FCLK);
        if (!PORESETn) begin
            m_req = 0; m_low_seen = 0; m_wait_rel = 0;
            m_age = 0; m_hold_left = 0;
            m_run[0] = 0; m_run[1] = 0; m_run[2] = 0;
            m_cause = 5'b10000;
        end else begin
            src = {(m_run[2] >= DEB), (LOCKUP && LOCKUPRESET), WDOGRES, CPURSTREQ};
            busy_before = m_req || m_wait_rel || (m_hold_left > 0);
            if (!busy_before && src != 4'd0)
                m_cause = (CAUSECLR ? 5'b00000 : m_cause) | {1'b0, src};
            else if (CAUSECLR)
                m_cause = 5'b00000;
            if (!busy_before) begin
                if (src != 4'd0) begin
                    m_req = 1; m_age = 1; m_low_seen = 0;
                end
            end else if (m_req) begin
                if (m_age >= MINP && m_low_seen) begin
                    m_req = 0; m_wait_rel = 1;
                end else begin
                    if (m_age < MINP) m_age++;
                    if (!HRESETn) m_low_seen = 1;
                end
            end else if (m_wait_rel) begin
                if (HRESETn) begin
                    m_wait_rel = 0; m_hold_left = HOLD;
                end
            end else begin
                m_hold_left--;
            end
            newrun   = EXTRSTn ? 0 : ((m_run[0] < 1000) ? m_run[0] + 1 : m_run[0]);
            m_run[2] = m_run[1];
            m_run[1] = m_run[0];
            m_run[0] = newrun;
        end
        #1;
        check("model_req",   {31'd0, RSTREQOUT}, {31'd0, m_req});
        check("model_busy",  {31'd0, BUSY}, {31'd0, (m_req || m_wait_rel || (m_hold_left > 0))});
        check("model_cause", {27'd0, RSTCAUSE}, {27'd0, m_cause});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge FCLK);
    endtask

    task automatic wait_rise(output int n);
        n = 0;
        while (RSTREQOUT !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
    endtask

    // Called on the negedge where RSTREQOUT has just risen. Drives HRESETn low
    // lo_dly cycles later, releases it hi_dly cycles after RSTREQOUT falls,
    // and returns the request high time and cycles from the HRESETn-high
    // sample to BUSY falling.
    task automatic handshake(input int lo_dly, input int hi_dly, input bit cpu_in_hold,
                             output int hi_cycles, output int tail);
        int k;
        k = 0;
        hi_cycles = 0;
        while (RSTREQOUT === 1'b1 && k < 100) begin
            if (k == lo_dly) HRESETn = 1'b0;
            hi_cycles++;
            tick(1);
            k++;
        end
        if (k >= 100) check("req_fall_timeout", {31'd0, RSTREQOUT}, 32'd0);
        repeat (hi_dly) tick(1);
        HRESETn = 1'b1;
        tick(1);
        tail = 0;
        while (BUSY === 1'b1 && tail < 100) begin
            CPURSTREQ = cpu_in_hold && (tail == 2);
            tick(1);
            tail++;
        end
        CPURSTREQ = 1'b0;
    endtask

    initial begin
        int  hi, tl, n;
        bit  saw_busy;
        PORESETn = 0; CPURSTREQ = 0; WDOGRES = 0; LOCKUP = 0; LOCKUPRESET = 0;
        EXTRSTn = 1; HRESETn = 1; CAUSECLR = 0;
        tick(3);
        PORESETn = 1;
        tick(2);
        // Power-on state
        check("por_cause", {27'd0, RSTCAUSE}, 32'h10);
        check("por_req",   {31'd0, RSTREQOUT}, 32'd0);
        check("por_busy",  {31'd0, BUSY}, 32'd0);

        // CPU single-cycle request
        CPURSTREQ = 1; tick(1); CPURSTREQ = 0;
        check("cpu_req_rise",  {31'd0, RSTREQOUT}, 32'd1);
        check("cpu_busy_rise", {31'd0, BUSY}, 32'd1);
        handshake(2, 3, 0, hi, tl);
        check("cpu_hi_cycles", hi, 32'd4);
        check("cpu_busy_tail", tl, 32'd8);
        check("cpu_cause",     {27'd0, RSTCAUSE}, 32'h11);

        // External pin bouncing: short burst must not request
        saw_busy = 0;
        EXTRSTn = 0;
        repeat (10) begin tick(1); if (BUSY) saw_busy = 1; end
        EXTRSTn = 1;
        tick(1); if (BUSY) saw_busy = 1;
        check("ext_bounce_quiet", {31'd0, saw_busy}, 32'd0);
        EXTRSTn = 0;
        wait_rise(n);
        check("ext_latency", n, 32'd19);
        EXTRSTn = 1;
        handshake(1, 1, 0, hi, tl);
        check("ext_cause", {27'd0, RSTCAUSE}, 32'h19);

        // Lockup gated by LOCKUPRESET; late HRESETn stretches the pulse
        LOCKUP = 1;
        tick(5);
        check("lockup_gated", {31'd0, BUSY}, 32'd0);
        LOCKUPRESET = 1;
        wait_rise(n);
        check("lockup_latency", n, 32'd1);
        LOCKUP = 0; LOCKUPRESET = 0;
        handshake(6, 0, 0, hi, tl);
        check("lockup_hi_cycles", hi, 32'd8);
        check("lockup_cause", {27'd0, RSTCAUSE}, 32'h1d);

        // Cause clear, then continuous watchdog with a CPU pulse during hold
        CAUSECLR = 1; tick(1); CAUSECLR = 0;
        check("clr_cause", {27'd0, RSTCAUSE}, 32'h0);
        WDOGRES = 1;
        wait_rise(n);
        check("wdog_latency", n, 32'd1);
        handshake(0, 0, 1, hi, tl);
        check("wdog_hi_cycles", hi, 32'd4);
        check("wdog_busy_tail", tl, 32'd8);
        wait_rise(n);
        check("wdog_idle_gap", n, 32'd1);
        check("wdog_cause_no_cpu", {27'd0, RSTCAUSE}, 32'h02);
        WDOGRES = 0;
        handshake(2, 2, 0, hi, tl);

        // Set beats clear on a coinciding capture
        CPURSTREQ = 1; tick(1); CPURSTREQ = 0;
        handshake(1, 1, 0, hi, tl);
        check("pre_clr_cause", {27'd0, RSTCAUSE}, 32'h03);
        WDOGRES = 1; CAUSECLR = 1;
        tick(1);
        WDOGRES = 0; CAUSECLR = 0;
        check("clr_vs_capture", {27'd0, RSTCAUSE}, 32'h02);
        check("clr_vs_capture_req", {31'd0, RSTREQOUT}, 32'd1);

        // Power-on reset in the middle of ASSERT
        tick(1);
        PORESETn = 0;
        #1;
        check("midseq_por_req",   {31'd0, RSTREQOUT}, 32'd0);
        check("midseq_por_busy",  {31'd0, BUSY}, 32'd0);
        check("midseq_por_cause", {27'd0, RSTCAUSE}, 32'h10);
        tick(2);
        PORESETn = 1;
        tick(3);
        check("post_por_busy",  {31'd0, BUSY}, 32'd0);
        check("post_por_cause", {27'd0, RSTCAUSE}, 32'h10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule : tb_cm0_rst_req_seq
`default_nettype wire
